// File: rtl/operand_entry.sv
// Operand entry front end: synchronises and debounces three push-buttons,
// then latches A/B from the switches and steps the function code.
module operand_entry #(
  parameter int width    = 6,
  parameter int DEBOUNCE = 250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] sw,
  input  logic             key_load_n,
  input  logic             key_func_n,
  input  logic             key_clr_n,
  output logic [width-1:0] a,
  output logic [width-1:0] b,
  output logic [2:0]       func,
  output logic [1:0]       entry_state
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RUN     = 2'b10
  } state_e;

  // Key index: 0 = load, 1 = func, 2 = clear
  logic [2:0] key_raw;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] lvl_q, lvl_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] press_q, press_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  state_e           state_q, state_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [2:0]       func_q, func_d;

  assign key_raw = {key_clr_n, key_func_n, key_load_n};

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    prev_d  = lvl_q;
    press_d = prev_q & ~lvl_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        lvl_d[i] = ~lvl_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    func_d  = func_q;
    if (press_q[2]) begin
      a_d     = '0;
      b_d     = '0;
      func_d  = '0;
      state_d = ENTER_A;
    end else begin
      if (press_q[1]) begin
        func_d = func_q + 3'd1;
      end
      if (press_q[0]) begin
        unique case (state_q)
          ENTER_A, RUN: begin
            a_d     = sw;
            state_d = ENTER_B;
          end
          ENTER_B: begin
            b_d     = sw;
            state_d = RUN;
          end
          default: state_d = ENTER_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      lvl_q   <= '1;
      prev_q  <= '1;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
    end
  end

  // Display select is forced while operands are being keyed in
  assign a           = a_q;
  assign b           = b_q;
  assign func        = {(state_q == RUN) ? func_q[2] : 1'b1, func_q[1:0]};
  assign entry_state = state_q;

endmodule
